// File: rtl/solar_track_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : solar_track_ctrl
// Description : Two-axis solar tracker motor sequencer. Each accepted sample
//               of the four light sensors is resolved north/south first, then
//               east/west. An axis moves only when its imbalance exceeds HYST.
//               A move is a STEP_CYCLES motor pulse followed by a
//               SETTLE_CYCLES dwell. At most one motor output is ever high.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous active-high reset
//               en           - controller enable (low aborts a sample)
//               sample_valid - sensor buses valid this cycle (IDLE only)
//               LSN/LSE/LSS/LSW - 8-bit light sensor readings
//               MN/ME/MS/MW  - motor drives (decoded from registered state)
//               busy         - state is not IDLE
//               locked       - last completed sample needed no movement
// Revision    : 1.0 - initial release
// ============================================================================
module solar_track_ctrl #(
  parameter int HYST          = 10,
  parameter int STEP_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sample_valid,
  input  logic [7:0] LSN,
  input  logic [7:0] LSE,
  input  logic [7:0] LSS,
  input  logic [7:0] LSW,
  output logic       MN,
  output logic       ME,
  output logic       MS,
  output logic       MW,
  output logic       busy,
  output logic       locked
);

  // Counter only has to hold the larger of the two reload values.
  localparam int c_MAXC = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int c_CW   = (c_MAXC > 1) ? $clog2(c_MAXC) : 1;

  localparam logic [c_CW-1:0] c_STEP_LOAD   = c_CW'(STEP_CYCLES - 1);
  localparam logic [c_CW-1:0] c_SETTLE_LOAD = c_CW'(SETTLE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_ONE         = c_CW'(1);
  localparam logic [8:0]      c_HYST9       = 9'(HYST);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_DEC_NS = 3'd1;
  localparam logic [2:0] c_DRV_NS = 3'd2;
  localparam logic [2:0] c_SET_NS = 3'd3;
  localparam logic [2:0] c_DEC_EW = 3'd4;
  localparam logic [2:0] c_DRV_EW = 3'd5;
  localparam logic [2:0] c_SET_EW = 3'd6;

  logic [2:0]      r_state;
  logic [7:0]      r_n, r_e, r_s, r_w;
  logic [c_CW-1:0] r_cnt;
  logic            r_dir;     // 0: north/east motor, 1: south/west motor
  logic            r_moved;
  logic            r_locked;

  logic [2:0]      w_state_nxt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic            w_dir_nxt;
  logic            w_moved_nxt;
  logic            w_locked_nxt;
  logic            w_accept;

  // Comparisons at 9 bits so a reading near 255 plus HYST cannot wrap.
  logic w_n_gt, w_s_gt, w_e_gt, w_w_gt;
  assign w_n_gt = {1'b0, r_n} > ({1'b0, r_s} + c_HYST9);
  assign w_s_gt = {1'b0, r_s} > ({1'b0, r_n} + c_HYST9);
  assign w_e_gt = {1'b0, r_e} > ({1'b0, r_w} + c_HYST9);
  assign w_w_gt = {1'b0, r_w} > ({1'b0, r_e} + c_HYST9);

  assign w_accept = (r_state == c_IDLE) && en && sample_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_n      <= '0;
      r_e      <= '0;
      r_s      <= '0;
      r_w      <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_moved  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir    <= w_dir_nxt;
      r_moved  <= w_moved_nxt;
      r_locked <= w_locked_nxt;
      if (w_accept) begin
        r_n <= LSN;
        r_e <= LSE;
        r_s <= LSS;
        r_w <= LSW;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dir_nxt    = r_dir;
    w_moved_nxt  = r_moved;
    w_locked_nxt = r_locked;

    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_nxt = c_DEC_NS;
          w_moved_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      c_DEC_NS: begin
        if (w_n_gt || w_s_gt) begin
          w_state_nxt = c_DRV_NS;
          w_dir_nxt   = ~w_n_gt;  // north wins if both were ever true
          w_moved_nxt = 1'b1;
          w_cnt_nxt   = c_STEP_LOAD;
        end else begin
          w_state_nxt = c_DEC_EW;
        end
      end
      c_DRV_NS: begin
        if (r_cnt == '0) begin
          w_state_nxt = c_SET_NS;
          w_cnt_nxt   = c_SETTLE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      c_SET_NS: begin
        if (r_cnt == '0) begin
          w_state_nxt = c_DEC_EW;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      c_DEC_EW: begin
        if (w_e_gt || w_w_gt) begin
          w_state_nxt = c_DRV_EW;
          w_dir_nxt   = ~w_e_gt;
          w_moved_nxt = 1'b1;
          w_cnt_nxt   = c_STEP_LOAD;
        end else begin
          w_state_nxt  = c_IDLE;
          w_locked_nxt = ~r_moved;
        end
      end
      c_DRV_EW: begin
        if (r_cnt == '0) begin
          w_state_nxt = c_SET_EW;
          w_cnt_nxt   = c_SETTLE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      c_SET_EW: begin
        if (r_cnt == '0) begin
          w_state_nxt  = c_IDLE;
          w_locked_nxt = ~r_moved;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase

    // Dropping enable mid-sample discards it; the tracker is no longer
    // known to be aligned, so locked is cleared.
    if ((r_state != c_IDLE) && !en) begin
      w_state_nxt  = c_IDLE;
      w_cnt_nxt    = '0;
      w_locked_nxt = 1'b0;
    end
  end

  // Output decode: motors exist only in the drive states, which makes the
  // one-hot property structural and lets reset clear them immediately.
  always_comb begin
    MN     = (r_state == c_DRV_NS) && !r_dir;
    MS     = (r_state == c_DRV_NS) &&  r_dir;
    ME     = (r_state == c_DRV_EW) && !r_dir;
    MW     = (r_state == c_DRV_EW) &&  r_dir;
    busy   = (r_state != c_IDLE);
    locked = r_locked;
  end

endmodule
`default_nettype wire

// File: tb/tb_solar_track_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_solar_track_ctrl
// Description : Self-checking bench for solar_track_ctrl. A behavioural model
//               expands each sample into the expected per-cycle output trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_solar_track_ctrl;

  localparam int HYST   = 10;
  localparam int STEP   = 16;
  localparam int SETTLE = 8;

  logic       clk = 1'b0;
  logic       rst, en, sv;
  logic [7:0] lsn, lse, lss, lsw;
  logic       mn, me, ms, mw, busy, locked;

  int errors = 0;
  int checks = 0;

  // Expected {MN,ME,MS,MW,busy} for each cycle after the sample is taken.
  logic [4:0] q[$];
  logic       exp_locked;

  solar_track_ctrl #(
    .HYST(HYST), .STEP_CYCLES(STEP), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sample_valid(sv),
    .LSN(lsn), .LSE(lse), .LSS(lss), .LSW(lsw),
    .MN(mn), .ME(me), .MS(ms), .MW(mw),
    .busy(busy), .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] outs();
    return {mn, me, ms, mw, busy};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // At most one motor high in every cycle.
  always @(negedge clk) begin
    checks++;
    assert ($onehot0({mn, me, ms, mw})) else begin
      errors++;
      $error("FAIL mutex: observed=%b expected=onehot0", {mn, me, ms, mw});
    end
  end

  // One axis: a pulse of STEP cycles on the winning motor, then SETTLE dwell.
  task automatic axis(input int a, input int b, input logic [4:0] pa,
                      input logic [4:0] pb, inout bit moved);
    logic [4:0] p;
    if (a > b + HYST)      p = pa;
    else if (b > a + HYST) p = pb;
    else                   return;
    moved = 1'b1;
    repeat (STEP)   q.push_back(p);
    repeat (SETTLE) q.push_back(5'b00001);
  endtask

  task automatic model(input int n, input int e, input int s, input int w);
    bit moved = 1'b0;
    q.delete();
    q.push_back(5'b00001);                            // N/S decision
    axis(n, s, 5'b10001, 5'b00101, moved);
    q.push_back(5'b00001);                            // E/W decision
    axis(e, w, 5'b01001, 5'b00011, moved);
    exp_locked = !moved;
  endtask

  // Present one sample and check every cycle until the controller is idle.
  // abort_at: trace index after whose check en is dropped (-1 = none).
  // noise: scramble live sensors and pulse sample_valid while busy.
  task automatic run_sample(input int n, input int e, input int s, input int w,
                            input int abort_at, input bit noise, input string tag);
    model(n, e, s, w);
    @(negedge clk);
    lsn = 8'(n); lse = 8'(e); lss = 8'(s); lsw = 8'(w); sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("%s[%0d]", tag, i), outs(), q[i]);
      if (i == abort_at) begin
        en = 1'b0; sv = 1'b0;
        @(negedge clk);
        chk({tag, "_abort_outs"}, outs(), 5'b00000);
        chk({tag, "_abort_locked"}, {4'b0, locked}, 5'b00000);
        en = 1'b1;
        return;
      end
      if (noise) begin
        sv  = ($urandom_range(0, 3) == 0);
        lsn = 8'($urandom); lse = 8'($urandom);
        lss = 8'($urandom); lsw = 8'($urandom);
      end
      @(negedge clk);
    end
    sv = 1'b0;
    chk({tag, "_idle"}, outs(), 5'b00000);
    chk({tag, "_locked"}, {4'b0, locked}, {4'b0, exp_locked});
  endtask

  function automatic int clip(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic int partner(input int s);
    int d = int'($urandom_range(0, 2)) - 1;
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 255));
      1:       return clip(s + HYST + d);
      default: return clip(s - HYST - d);
    endcase
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; sv = 1'b0;
    lsn = '0; lse = '0; lss = '0; lsw = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 5'b00000);
    chk("reset_locked", {4'b0, locked}, 5'b00000);
    rst = 1'b0;
    en  = 1'b1;

    run_sample(100, 50, 80, 50, -1, 1'b0, "pulse_n");
    run_sample(90, 60, 80, 60, -1, 1'b0, "tie");

    // Asynchronous reset in the middle of an MN pulse.
    @(negedge clk);
    lsn = 8'd100; lss = 8'd80; lse = 8'd50; lsw = 8'd50; sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_mn", outs(), 5'b10001);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs", outs(), 5'b00000);
    chk("rst_async_locked", {4'b0, locked}, 5'b00000);
    @(negedge clk);
    chk("rst_held_outs", outs(), 5'b00000);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_outs", outs(), 5'b00000);

    run_sample(250, 77, 255, 77, -1, 1'b0, "nowrap");
    run_sample(244, 100, 255, 200, -1, 1'b0, "both");
    // Index 30 is the 5th cycle of the E/W drive.
    run_sample(244, 100, 255, 200, 30, 1'b1, "abort");

    // Disabled: sample pulses with a strong imbalance must be ignored.
    @(negedge clk);
    en = 1'b0; lsn = 8'd200; lss = 8'd0;
    for (int i = 0; i < 8; i++) begin
      sv = i[0];
      @(negedge clk);
      chk($sformatf("disabled[%0d]", i), outs(), 5'b00000);
      chk($sformatf("disabled_locked[%0d]", i), {4'b0, locked}, 5'b00000);
    end
    sv = 1'b0;
    en = 1'b1;

    for (int k = 0; k < 40; k++) begin
      int s, n, w, e;
      s = int'($urandom_range(0, 255));
      n = partner(s);
      w = int'($urandom_range(0, 255));
      e = partner(w);
      run_sample(n, e, s, w, -1, 1'b1, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
